// File: rtl/led_matrix_scan_capture_if.sv
// Bundle for led_matrix_scan_capture: scanned row/col lines and read address in,
// committed-frame read data and status flags out.
interface led_matrix_scan_capture_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [RW-1:0]   rd_row;
    logic [COLS-1:0] rd_data;
    logic            frame_stb;
    logic [15:0]     frame_cnt;
    logic            err_multi;
    logic            stalled;

    modport master (
        output row, col, rd_row,
        input  rd_data, frame_stb, frame_cnt, err_multi, stalled
    );

    modport slave (
        input  row, col, rd_row,
        output rd_data, frame_stb, frame_cnt, err_multi, stalled
    );
endinterface

// File: rtl/led_matrix_scan_capture.sv
// Receive side of a multiplexed LED-matrix scan: rebuilds the ROWS x COLS frame from the
// row-select/column-drive lines. Optional idle watchdog: LED_MATRIX_CAP_WATCHDOG_EN.
module led_matrix_scan_capture #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_200_000
) (
    input logic                      clk,
    input logic                      rst_n,
    led_matrix_scan_capture_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

    logic [ROWS-1:0] row_meta, row_sync, row_last;
    logic [COLS-1:0] col_meta, col_sync;
    state_t          state, state_next;
    logic [7:0]      settle_cnt;
    logic            settle_clr, settle_inc;
    logic            sample_en, err_set, commit_q, wd_fire;
    int              ones_cnt;
    logic            row_zero, row_onehot, row_multi, row_changed;
    logic [RW-1:0]   row_idx;
    logic [COLS-1:0] shadow [ROWS];
    logic [COLS-1:0] frame  [ROWS];
    logic [ROWS-1:0] seen, seen_next;
    logic [COLS-1:0] rd_data_q;
    logic            frame_stb_q, err_multi_q;
    logic [15:0]     frame_cnt_q;

    // Columns idle high (active-low drive), so their synchronisers reset to all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '0;
            row_sync <= '0;
            row_last <= '0;
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            row_meta <= bus.row;
            row_sync <= row_meta;
            row_last <= row_sync;
            col_meta <= bus.col;
            col_sync <= col_meta;
        end
    end

    always_comb begin
        ones_cnt = 0;
        row_idx  = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_sync[i]) begin
                ones_cnt = ones_cnt + 1;
                row_idx  = RW'(i);
            end
        end
        row_zero   = (ones_cnt == 0);
        row_onehot = (ones_cnt == 1);
        row_multi  = (ones_cnt > 1);
    end

    assign row_changed = (row_sync != row_last);
    assign seen_next   = seen | (ROWS'(1) << row_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // SAMPLE only writes if the row is still unchanged, so the columns belong to it.
    always_comb begin
        state_next = state;
        settle_clr = 1'b0;
        settle_inc = 1'b0;
        sample_en  = 1'b0;
        err_set    = 1'b0;
        if (row_multi) begin
            state_next = IDLE;
            err_set    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (row_onehot) begin
                        state_next = SETTLE;
                        settle_clr = 1'b1;
                    end
                end
                SETTLE: begin
                    if (row_zero)
                        state_next = IDLE;
                    else if (row_changed)
                        settle_clr = 1'b1;
                    else if (settle_cnt == 8'(SETTLE_CYCLES - 1))
                        state_next = SAMPLE;
                    else
                        settle_inc = 1'b1;
                end
                SAMPLE, HOLD: begin
                    if (row_changed) begin
                        if (row_zero) begin
                            state_next = IDLE;
                        end else begin
                            state_next = SETTLE;
                            settle_clr = 1'b1;
                        end
                    end else if (state == SAMPLE) begin
                        sample_en  = 1'b1;
                        state_next = HOLD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt  <= '0;
            err_multi_q <= 1'b0;
        end else begin
            if (settle_clr)      settle_cnt <= '0;
            else if (settle_inc) settle_cnt <= settle_cnt + 8'd1;
            if (err_set)         err_multi_q <= 1'b1;
        end
    end

    // The commit runs the cycle after the completing SAMPLE; frame_stb and frame_cnt
    // change together with the frame buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                shadow[i] <= '0;
                frame[i]  <= '0;
            end
            seen        <= '0;
            commit_q    <= 1'b0;
            frame_stb_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            commit_q    <= sample_en && (seen_next == '1);
            frame_stb_q <= commit_q;
            if (commit_q) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (wd_fire) begin
                for (int i = 0; i < ROWS; i++) begin
                    shadow[i] <= '0;
                    frame[i]  <= '0;
                end
                seen <= '0;
            end else if (sample_en) begin
                shadow[row_idx] <= ~col_sync;
                seen            <= seen_next;
            end else if (commit_q) begin
                for (int i = 0; i < ROWS; i++) frame[i] <= shadow[i];
                seen <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      rd_data_q <= '0;
        else if (int'(bus.rd_row) < ROWS) rd_data_q <= frame[bus.rd_row];
        else                             rd_data_q <= '0;
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.frame_stb = frame_stb_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_multi = err_multi_q;

`ifdef LED_MATRIX_CAP_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;
    logic           stalled_q;

    assign wd_fire = !sample_en && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    // Counts cycles since the last SAMPLE and saturates at the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            stalled_q <= 1'b0;
        end else if (sample_en) begin
            wd_cnt    <= '0;
            stalled_q <= 1'b0;
        end else if (wd_fire) begin
            wd_cnt    <= WDW'(TIMEOUT_CYCLES);
            stalled_q <= 1'b1;
        end else if (wd_cnt != WDW'(TIMEOUT_CYCLES)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign bus.stalled = stalled_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_fire        = 1'b0;
    assign bus.stalled    = 1'b0;
`endif
endmodule

// File: tb/tb_led_matrix_scan_capture.sv
// Directed scoreboard bench for led_matrix_scan_capture: sweeps, glitch, multi-hot,
// counter wrap and (when LED_MATRIX_CAP_WATCHDOG_EN is defined) the idle watchdog.
module tb_led_matrix_scan_capture;
    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_matrix_scan_capture_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_matrix_scan_capture #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          errors    = 0;
    int          checks    = 0;
    int          stb_count = 0;
    logic [15:0] exp_cnt   = 16'd0;
    logic [15:0] cnt_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  pat [ROWS];

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every frame_stb pops the next expected frame_cnt from the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.frame_stb === 1'b1) begin
            stb_count++;
            if (cnt_q.size() == 0)
                checkOutput("unexpected_frame_stb", 16'(bus.frame_stb), 16'd0);
            else
                checkOutput("frame_cnt_at_stb", bus.frame_cnt, cnt_q.pop_front());
        end
    end

    task automatic scanRow(input int r, input logic [7:0] pixels, input int hold);
        bus.row = ROWS'(1) << r;
        bus.col = ~pixels;
        repeat (hold) @(negedge clk);
        bus.row = '0;
        bus.col = '1;
        repeat (5) @(negedge clk);
    endtask

    task automatic applyStimulus(input int first, input int last);
        for (int r = first; r <= last; r++) scanRow(r, pat[r], 20);
    endtask

    task automatic expectCommit();
        exp_cnt = exp_cnt + 16'd1;
        cnt_q.push_back(exp_cnt);
    endtask

    task automatic readFrame(input string tag, input bit zero);
        for (int r = 0; r < ROWS; r++) rd_q.push_back(zero ? 8'h00 : pat[r]);
        for (int r = 0; r < ROWS; r++) begin
            bus.rd_row = 3'(r);
            @(negedge clk);
            checkOutput(tag, 16'(bus.rd_data), 16'(rd_q.pop_front()));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        bus.row    = '0;
        bus.col    = '1;
        bus.rd_row = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while a row is being scanned.
        bus.row = 8'h01;
        bus.col = 8'hFE;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_rd_data", 16'(bus.rd_data), 16'd0);
        checkOutput("reset_frame_stb", 16'(bus.frame_stb), 16'd0);
        checkOutput("reset_frame_cnt", bus.frame_cnt, 16'd0);
        checkOutput("reset_err_multi", 16'(bus.err_multi), 16'd0);
        checkOutput("reset_stalled", 16'(bus.stalled), 16'd0);
        repeat (2) @(negedge clk);
        bus.row = '0;
        bus.col = '1;
        @(negedge clk);
        rst_n = 1'b1;
        readFrame("post_reset_rd_data", 1'b1);
        checkOutput("post_reset_frame_cnt", bus.frame_cnt, 16'd0);

        // Diagonal sweep.
        for (int r = 0; r < ROWS; r++) pat[r] = 8'(1) << r;
        expectCommit();
        applyStimulus(0, 7);
        repeat (4) @(negedge clk);
        checkOutput("sweep1_stb_count", 16'(stb_count), 16'd1);
        checkOutput("sweep1_frame_cnt", bus.frame_cnt, 16'd1);
        readFrame("sweep1_rd_data", 1'b0);

        // Short row-3 glitch after row 3 was captured must not replace it.
        for (int r = 0; r < ROWS; r++) pat[r] = 8'hA5 ^ 8'(r * 17);
        expectCommit();
        applyStimulus(0, 5);
        bus.row = 8'h08;
        bus.col = 8'h00;
        repeat (3) @(negedge clk);
        bus.row = '0;
        bus.col = '1;
        repeat (5) @(negedge clk);
        applyStimulus(6, 7);
        repeat (4) @(negedge clk);
        checkOutput("glitch_stb_count", 16'(stb_count), 16'd2);
        readFrame("glitch_rd_data", 1'b0);

        // Multi-hot rows 2+4 mid-sweep: flagged, not sampled.
        for (int r = 0; r < ROWS; r++) pat[r] = 8'h3C ^ 8'(r * 29);
        expectCommit();
        applyStimulus(0, 4);
        bus.row = 8'b0001_0100;
        bus.col = 8'h00;
        repeat (10) @(negedge clk);
        checkOutput("err_multi_set", 16'(bus.err_multi), 16'd1);
        bus.row = '0;
        bus.col = '1;
        repeat (5) @(negedge clk);
        applyStimulus(5, 7);
        repeat (4) @(negedge clk);
        checkOutput("err_multi_sticky", 16'(bus.err_multi), 16'd1);
        readFrame("multi_rd_data", 1'b0);

        for (int r = 0; r < ROWS; r++) pat[r] = 8'hC3 ^ 8'(r);
        expectCommit();
        applyStimulus(0, 7);
        repeat (4) @(negedge clk);
        checkOutput("clean_stb_count", 16'(stb_count), 16'd4);
        readFrame("clean_rd_data", 1'b0);

        // Counter wrap from 0xFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        checkOutput("forced_frame_cnt", bus.frame_cnt, 16'hFFFF);
        for (int r = 0; r < ROWS; r++) pat[r] = 8'h80 >> r;
        expectCommit();
        applyStimulus(0, 7);
        repeat (4) @(negedge clk);
        checkOutput("wrap_stb_count", 16'(stb_count), 16'd5);
        checkOutput("wrap_frame_cnt", bus.frame_cnt, 16'd0);
        readFrame("wrap_rd_data", 1'b0);

`ifdef LED_MATRIX_CAP_WATCHDOG_EN
        repeat (110) @(negedge clk);
        checkOutput("stalled_set", 16'(bus.stalled), 16'd1);
        readFrame("stalled_rd_data", 1'b1);
        scanRow(0, 8'h5A, 20);
        checkOutput("stalled_clear", 16'(bus.stalled), 16'd0);
`else
        repeat (150) @(negedge clk);
        checkOutput("stalled_tied", 16'(bus.stalled), 16'd0);
        readFrame("idle_hold_rd_data", 1'b0);
`endif

        checkOutput("pending_commits", 16'(cnt_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_matrix_scan_capture.md
Name: led_matrix_scan_capture

Overview:
- Receive side of the multiplexed LED-matrix scan interface (row select + column drive) produced by the game top.
- Samples the scanned row/col lines, reconstructs the displayed ROWS x COLS frame, and exposes it through a registered read port plus a frame strobe.
- Used as an on-chip display mirror (debug/readback) and as a reusable checker in benches.

Parameters:
- ROWS, 8, number of matrix rows (row select width).
- COLS, 8, number of matrix columns (col drive width).
- SETTLE_CYCLES, 4, consecutive clk cycles a row selection must stay unchanged before its columns are sampled (range 1..255).
- TIMEOUT_CYCLES, 1_200_000, idle limit for the optional watchdog (about 100 ms at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- row  in  ROWS  row select, active-high, one-hot while a row is lit; all-zero means blanking.
- col  in  COLS  column drive, active-low (pixel on when bit = 0).
- rd_row  in  clog2(ROWS)  read address into the committed frame.
- rd_data  out  COLS  committed pixels of row rd_row, 1 = on; registered.
- frame_stb  out  1  one-cycle pulse when a complete frame is committed.
- frame_cnt  out  16  committed-frame counter, wraps 0xFFFF -> 0.
- err_multi  out  1  sticky; set when more than one row bit is high after synchronisation.
- stalled  out  1  watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, synchronous release by design): frame buffer, shadow buffer, seen mask, counters, rd_data, frame_stb, frame_cnt, err_multi and stalled are all 0. Synchroniser flops reset to row = 0 and col = all-ones.
- Input sync: row and col each pass through a 2-FF synchroniser. All logic below uses the synchronised values (2-cycle input latency).
- Row tracking FSM:
  - IDLE: synced row = 0. Stay in IDLE.
  - SETTLE: entered on any change to a valid one-hot value. A counter runs; if row changes before the counter reaches SETTLE_CYCLES, restart SETTLE with the new value.
  - SAMPLE: single cycle. Write ~col into shadow[idx], where idx is the encoded one-hot position. Set seen[idx].
  - HOLD: wait until row changes. Change to 0 goes to IDLE; change to another one-hot value goes to SETTLE; multi-hot goes to IDLE and sets err_multi.
- Multi-hot row in any state: no sampling, FSM goes to IDLE, err_multi set. err_multi clears only on reset.
- Commit: on the cycle after a SAMPLE that makes seen all-ones:
  - copy shadow to frame buffer;
  - pulse frame_stb for 1 cycle;
  - increment frame_cnt;
  - clear seen.
- Repeated capture of the same row before commit overwrites that shadow row; the latest sample wins.
- Read port: rd_data <= frame[rd_row] every clk (1-cycle latency). rd_row >= ROWS returns 0.
- A read in the same cycle as a commit returns pre-commit data. The new data is visible on the next read.
- Rows never scanned: no commit ever occurs; the frame buffer holds its previous contents.

Optional Feature:
- Macro LED_MATRIX_CAP_WATCHDOG_EN.
- Defined:
  - A counter counts cycles since the last SAMPLE.
  - At TIMEOUT_CYCLES it sets stalled, clears frame buffer, shadow buffer and seen, and saturates.
  - The next SAMPLE clears stalled and restarts the counter.
- Undefined: no counter is built, stalled is constant 0, and the frame buffer holds its contents indefinitely.

Test Plan:
- Reset while scanning -> all outputs 0; after release, rd_data = 0 for every rd_row; frame_cnt = 0.
- Scan rows 0..7, each held 20 cycles with col = ~(8'h01 << r), 5 blank cycles between rows -> exactly one frame_stb; frame_cnt = 1; rd_data[r] = 8'h01 << r, one cycle after rd_row = r.
- Row 3 glitches for 3 cycles (less than SETTLE = 4) inside a sweep -> shadow row 3 unchanged by the glitch; commit contents match the stable scan only.
- row = 8'b0001_0100 for 10 cycles -> err_multi = 1 and stays 1; no sample taken; a subsequent full clean sweep still commits correctly.
- 65 536 full sweeps (or force frame_cnt = 0xFFFF) -> frame_cnt wraps to 0 on the next commit, and frame_stb still pulses.
- LED_MATRIX_CAP_WATCHDOG_EN with TIMEOUT_CYCLES = 100: commit a frame, then hold row = 0 for 100 cycles -> stalled = 1 and rd_data = 0 for all rows; next valid row sample -> stalled = 0.
